bus_merge_arbiter: RTL and testbench

- Registered 2-to-1 merge point for the SAP-1 8-bit data path; it performs the reverse job of the 1-to-2 bus splitter.
- Two independent 8-bit sources offer words under a valid/ready handshake. A round-robin arbiter picks one per cycle.
- The granted word is captured into a one-entry output register and presented to a single downstream consumer, tagged with its source index.
- Per-source transfer counters support bring-up and debug of the W-bus traffic.

---
 rtl/bus_merge_arbiter.sv | 103 ++++++++++
 tb/tb_bus_merge_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bus_merge_arbiter.sv
// Registered 2-to-1 merge point: round-robin arbitration between two valid/ready
// sources into a one-entry output register, with per-source transfer counters.
module bus_merge_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic             valid0,
    output logic             ready0,
    input  logic [WIDTH-1:0] in1,
    input  logic             valid1,
    output logic             ready1,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sel,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_sel_q, out_sel_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic can_accept;
    logic grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            out_q        <= '0;
            out_sel_q    <= 1'b0;
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            out_sel_q    <= out_sel_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    always_comb begin
        // A full register may still accept when the consumer drains it this cycle.
        can_accept = (state_q == EMPTY) || out_ready;

        // On a tie the source that did not win last time goes first.
        if (valid0 && valid1) begin
            grant = ~last_grant_q;
        end else begin
            grant = valid1;
        end

        ready0 = can_accept && valid0 && !grant;
        ready1 = can_accept && valid1 && grant;

        state_d      = state_q;
        out_d        = out_q;
        out_sel_d    = out_sel_q;
        last_grant_d = last_grant_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;

        if (ready0) begin
            state_d      = FULL;
            out_d        = in0;
            out_sel_d    = 1'b0;
            last_grant_d = 1'b0;
            cnt0_d       = cnt0_q + CNT_ONE;
        end else if (ready1) begin
            state_d      = FULL;
            out_d        = in1;
            out_sel_d    = 1'b1;
            last_grant_d = 1'b1;
            cnt1_d       = cnt1_q + CNT_ONE;
        end else if ((state_q == FULL) && out_ready) begin
            // Drain without a replacement word: data and tag are left as they were.
            state_d = EMPTY;
        end
    end

    assign out       = out_q;
    assign out_sel   = out_sel_q;
    assign out_valid = (state_q == FULL);
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_bus_merge_arbiter.sv
// Bench for bus_merge_arbiter: hand-written vector table plus a behavioural
// model with a scoreboard queue checked whenever the consumer drains a word.
module tb_bus_merge_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in0, in1, dout;
    logic       valid0, valid1, ready0, ready1;
    logic       out_valid, out_ready, out_sel;
    logic [7:0] cnt0, cnt1;

    always #5 clk = ~clk;

    bus_merge_arbiter #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in0(in0), .valid0(valid0), .ready0(ready0),
        .in1(in1), .valid1(valid1), .ready1(ready1),
        .out(dout), .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    typedef struct {
        logic       rst_first;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       ordy;
        logic       er0;
        logic       er1;
        logic       eov;
        logic [7:0] eout;
        logic       esel;
    } vec_t;

    vec_t vecs[15];

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state and scoreboard of {sel, data} words awaiting drain.
    logic       m_full;
    logic       m_last;
    logic [7:0] m_cnt0, m_cnt1;
    logic [8:0] sb[$];
    logic       s_r0, s_r1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_last = 1'b1;
        m_cnt0 = 8'd0;
        m_cnt1 = 8'd0;
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        valid0 = 1'b0;
        valid1 = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic step(input logic v0, input logic [7:0] d0, input logic v1,
                        input logic [7:0] d1, input logic ordy);
        logic       can, g, e0, e1;
        logic [8:0] w;
        @(negedge clk);
        in0 = d0; valid0 = v0; in1 = d1; valid1 = v1; out_ready = ordy;
        #1;
        can = !m_full || ordy;
        g   = (v0 && v1) ? !m_last : v1;
        e0  = can && v0 && !g;
        e1  = can && v1 && g;
        s_r0 = ready0;
        s_r1 = ready1;
        chk("model_ready0", ready0, e0);
        chk("model_ready1", ready1, e1);
        chk("ready_onehot", ready0 & ready1, 0);
        if (m_full && ordy) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: drain with no expected word");
            end else begin
                w = sb.pop_front();
                chk("drain_data", dout, w[7:0]);
                chk("drain_sel", out_sel, w[8]);
            end
        end
        if (e0) begin
            sb.push_back({1'b0, d0});
            m_full = 1'b1; m_last = 1'b0; m_cnt0 = m_cnt0 + 8'd1;
        end else if (e1) begin
            sb.push_back({1'b1, d1});
            m_full = 1'b1; m_last = 1'b1; m_cnt1 = m_cnt1 + 8'd1;
        end else if (m_full && ordy) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("model_out_valid", out_valid, m_full);
        chk("model_cnt0", cnt0, m_cnt0);
        chk("model_cnt1", cnt1, m_cnt1);
    endtask

    initial begin
        rst = 1'b0; in0 = 8'h00; in1 = 8'h00;
        valid0 = 1'b0; valid1 = 1'b0; out_ready = 1'b0;
        model_reset();

        //          rst   v0    d0     v1    d1     ordy  r0    r1    ov    out    sel
        vecs[0]  = '{1'b1, 1'b1, 8'h3A, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3A, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b0};

        do_reset();
        chk("rst_out", dout, 8'h00);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cnt0", cnt0, 8'h00);
        chk("rst_cnt1", cnt1, 8'h00);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].rst_first) do_reset();
            step(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].ordy);
            chk($sformatf("vec%0d_ready0", i), s_r0, vecs[i].er0);
            chk($sformatf("vec%0d_ready1", i), s_r1, vecs[i].er1);
            chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].eov);
            chk($sformatf("vec%0d_out", i), dout, vecs[i].eout);
            chk($sformatf("vec%0d_out_sel", i), out_sel, vecs[i].esel);
            if (i == 0) chk("vec0_cnt0", cnt0, 8'd1);
            if (i == 6) begin
                chk("rr_cnt0", cnt0, 8'd3);
                chk("rr_cnt1", cnt1, 8'd3);
            end
        end

        // 256 back-to-back accepts from source 0: counter wraps, no bubbles.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 8'(i), 1'b0, 8'h00, 1'b1);
            chk("b2b_out_valid", out_valid, 1);
        end
        chk("cnt0_wrap", cnt0, 8'd0);
        chk("b2b_last_word", dout, 8'hFF);

        // Asynchronous reset while full: cleared between edges.
        do_reset();
        step(1'b1, 8'h7F, 1'b0, 8'h00, 1'b0);
        chk("pre_arst_out", dout, 8'h7F);
        chk("pre_arst_valid", out_valid, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out", dout, 8'h00);
        chk("arst_cnt0", cnt0, 8'h00);
        chk("arst_cnt1", cnt1, 8'h00);
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        step(1'b1, 8'h01, 1'b1, 8'h02, 1'b1);
        chk("arst_tie_ready0", s_r0, 1);
        chk("arst_tie_sel", out_sel, 0);
        chk("arst_tie_out", dout, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
